counter_arb: RTL and testbench
==============================

COUNTER_ARB -- requirements
Module: counter_arb

Interface
REQ-001 SHALL provide parameter RR, default 1, meaning 1 = round-robin arbitration, 0 = fixed priority to requester 0.
REQ-002 SHALL provide port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL provide port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide ports req0 / req1  input  1  operation request from requester 0 / 1.
REQ-005 SHALL provide ports op0 / op1  input  2  requested counter command: 00 load, 01 increment, 10 decrement, 11 clear.
REQ-006 SHALL provide ports data0 / data1  input  8  load value, used only when op = 00.
REQ-007 SHALL provide ports gnt0 / gnt1  output  1  one-cycle grant pulse.
REQ-008 SHALL provide port done  output  1  one-cycle pulse: result valid.
REQ-009 SHALL provide port done_id  output  1  index of the requester that the done pulse belongs to.
REQ-010 SHALL provide port result  output  8  counter value after the granted operation.
REQ-011 SHALL provide port wrap  output  1  granted increment/decrement wrapped (255->0 or 0->255); qualified by done.
REQ-012 SHALL provide port busy  output  1  high in ISSUE and CAPTURE.
REQ-013 SHALL provide ports cnt_c  output  2, cnt_din  output  8, cnt_dout  input  8  command/data to, and value from, the shared 8-bit counter (00 load, 01 inc, 10 dec, 11 clear, updates every clk).

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, CAPTURE.
REQ-015 IDLE: if any req sampled high at clk edge -> ISSUE; otherwise stay IDLE.
REQ-016 On entry to ISSUE SHALL latch winner index, op and data; SHALL register gnt<winner>=1 for exactly the ISSUE cycle.
REQ-017 ISSUE: cnt_c = latched op, cnt_din = latched data (cnt_din = 0 when op != 00); always -> CAPTURE next edge.
REQ-018 CAPTURE: done=1, done_id=winner, result=cnt_dout, wrap=1 iff (op=01 and pre-op value=255) or (op=10 and pre-op value=0); pre-op value = cnt_dout sampled during ISSUE.
REQ-019 CAPTURE: if any req high -> ISSUE directly with new arbitration (2-cycle throughput); otherwise -> IDLE.
REQ-020 In IDLE and CAPTURE SHALL drive hold command cnt_c=00, cnt_din=cnt_dout so the counter retains its value.
REQ-021 RR=1: both requesting -> grant requester not granted last; last-winner pointer initialises so requester 0 wins first.
REQ-022 RR=0: both requesting -> requester 0 always wins.
REQ-023 Requester SHALL hold req, op, data stable until its gnt; req still high in the cycle after gnt counts as a new request.
REQ-024 result, done_id, wrap SHALL hold their last values outside done pulses; gnt0 and gnt1 SHALL never be high together.
REQ-025 Arithmetic is modulo 256; no saturation.

Reset
REQ-026 rst high SHALL immediately force state IDLE, and gnt0=gnt1=0, done=0, done_id=0, result=0, wrap=0, busy=0, cnt_c=00, cnt_din=cnt_dout, with pointer favouring requester 0.
REQ-027 Reset during ISSUE or CAPTURE SHALL abort the operation with no done pulse; the counter shares rst and reads 0 after reset.

Verification
REQ-028 After reset, req0 op=00 data=25 at edge 0 -> gnt0 in cycle 1, done=1, done_id=0, result=25 in cycle 2; then req0 op=01 -> result=26.
REQ-029 Counter=25, req0 op=01 and req1 op=10 raised together, held until granted, RR=1 -> gnt0 first with result=26, then gnt1 two cycles later with result=25.
REQ-030 Counter=0, req1 op=10 -> result=255, wrap=1; then op=01 -> result=0, wrap=1; then op=01 -> result=1, wrap=0.
REQ-031 No requests for 10 cycles at counter=77 -> cnt_c=00, cnt_din=77 every cycle, cnt_dout stays 77, busy=0.
REQ-032 rst pulsed during ISSUE -> gnt drops in the same cycle, no done pulse, state IDLE, result=0.
REQ-033 RR=0, both req held high continuously -> gnt0 every 2 cycles, gnt1 never.

Source files
------------

// File: rtl/counter_arb_if.sv
// Requester-side handshake and result bus of the counter arbiter.
interface counter_arb_if;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 2;

    // requester 0 / 1 commands
    logic              req0;
    logic              req1;
    logic [OP_W-1:0]   op0;
    logic [OP_W-1:0]   op1;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;

    // grants and completion reporting
    logic              gnt0;
    logic              gnt1;
    logic              done;
    logic              done_id;
    logic [DATA_W-1:0] result;
    logic              wrap;
    logic              busy;

    // requester side
    modport master (
        output req0, req1, op0, op1, data0, data1,
        input  gnt0, gnt1, done, done_id, result, wrap, busy
    );

    // arbiter side
    modport slave (
        input  req0, req1, op0, op1, data0, data1,
        output gnt0, gnt1, done, done_id, result, wrap, busy
    );
endinterface

// File: rtl/counter_arb.sv
// Two-requester arbiter in front of a shared 8-bit counter.
// One operation takes ISSUE (command on the counter port) then CAPTURE
// (result reported); back-to-back operations reach one per two cycles.
module counter_arb #(
    parameter bit RR = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    counter_arb_if.slave        bus,
    output logic [1:0]          cnt_c,
    output logic [7:0]          cnt_din,
    input  logic [7:0]          cnt_dout
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 2;

    localparam logic [OP_W-1:0] OP_LOAD = 2'b00;
    localparam logic [OP_W-1:0] OP_INC  = 2'b01;
    localparam logic [OP_W-1:0] OP_DEC  = 2'b10;
    localparam logic [OP_W-1:0] OP_CLR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ISSUE   = 2'b01,
        CAPTURE = 2'b10
    } state_t;

    // Latched command of the operation in flight.
    typedef struct packed {
        logic              winner;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] data;
    } cmd_t;

    state_t            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic              last_q, last_d;

    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              done_q, done_d;
    logic              done_id_q, done_id_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              wrap_q, wrap_d;
    logic              busy_q, busy_d;

    logic              any_req;
    logic              pick;
    logic [DATA_W-1:0] post_value;
    logic              post_wrap;

    // Counter value the shared counter will show after one command.
    function automatic logic [DATA_W-1:0] apply_op(
        input logic [OP_W-1:0]   op,
        input logic [DATA_W-1:0] din,
        input logic [DATA_W-1:0] cur
    );
        logic [DATA_W-1:0] nv;
        nv = cur;
        case (op)
            OP_LOAD: nv = din;
            OP_INC:  nv = cur + DATA_W'(1);
            OP_DEC:  nv = cur - DATA_W'(1);
            OP_CLR:  nv = '0;
            default: nv = cur;
        endcase
        return nv;
    endfunction

    // Arbitration: single requester wins outright; a tie goes to the
    // requester not granted last (RR=1) or always to requester 0 (RR=0).
    always_comb begin
        any_req = bus.req0 | bus.req1;
        pick    = 1'b0;
        if (bus.req0 && bus.req1) begin
            pick = RR ? ~last_q : 1'b0;
        end else if (bus.req1) begin
            pick = 1'b1;
        end
    end

    // Result and wrap of the command being issued, from the pre-op value.
    always_comb begin
        post_value = apply_op(cmd_q.op, cmd_q.data, cnt_dout);
        post_wrap  = ((cmd_q.op == OP_INC) && (cnt_dout == DATA_W'(8'hFF))) ||
                     ((cmd_q.op == OP_DEC) && (cnt_dout == DATA_W'(8'h00)));
    end

    // Next state and next values of all registered outputs.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        last_d    = last_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        result_d  = result_q;
        wrap_d    = wrap_q;

        case (state_q)
            IDLE, CAPTURE: begin
                if (any_req) begin
                    state_d      = ISSUE;
                    cmd_d.winner = pick;
                    cmd_d.op     = pick ? bus.op1   : bus.op0;
                    cmd_d.data   = pick ? bus.data1 : bus.data0;
                    last_d       = pick;
                    gnt0_d       = ~pick;
                    gnt1_d       = pick;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d   = CAPTURE;
                done_d    = 1'b1;
                done_id_d = cmd_q.winner;
                result_d  = post_value;
                wrap_d    = post_wrap;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, latched command and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            last_q    <= 1'b1;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            result_q  <= '0;
            wrap_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            last_q    <= last_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            result_q  <= result_d;
            wrap_q    <= wrap_d;
            busy_q    <= busy_d;
        end
    end

    // Counter port: the latched command in ISSUE, a hold (reload own value) otherwise.
    always_comb begin
        cnt_c   = OP_LOAD;
        cnt_din = cnt_dout;
        if (state_q == ISSUE) begin
            cnt_c   = cmd_q.op;
            cnt_din = (cmd_q.op == OP_LOAD) ? cmd_q.data : '0;
        end
    end

    assign bus.gnt0    = gnt0_q;
    assign bus.gnt1    = gnt1_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign bus.result  = result_q;
    assign bus.wrap    = wrap_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_counter_arb.sv
// Bench for counter_arb: a round-robin and a fixed-priority instance, each
// with its own shared counter, checked against a transaction-level model.
module tb_counter_arb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    counter_arb_if rr_if ();
    counter_arb_if fp_if ();

    logic [1:0] cc_rr, cc_fp;
    logic [7:0] din_rr, din_fp, dout_rr, dout_fp;

    counter_arb #(.RR(1'b1)) dut_rr (
        .clk(clk), .rst(rst), .bus(rr_if),
        .cnt_c(cc_rr), .cnt_din(din_rr), .cnt_dout(dout_rr)
    );

    counter_arb #(.RR(1'b0)) dut_fp (
        .clk(clk), .rst(rst), .bus(fp_if),
        .cnt_c(cc_fp), .cnt_din(din_fp), .cnt_dout(dout_fp)
    );

    // Shared counters (environment), reset together with the arbiters.
    function automatic logic [7:0] ctr_step(input logic [1:0] c, input logic [7:0] d, input logic [7:0] v);
        if (c == 2'b00) return d;
        if (c == 2'b01) return v + 8'd1;
        if (c == 2'b10) return v - 8'd1;
        return 8'd0;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_rr <= 8'd0;
            dout_fp <= 8'd0;
        end else begin
            dout_rr <= ctr_step(cc_rr, din_rr, dout_rr);
            dout_fp <= ctr_step(cc_fp, din_fp, dout_fp);
        end
    end

    // Requester drive, routed to the selected instance only.
    int         sel;
    logic       req0, req1;
    logic [1:0] op0, op1;
    logic [7:0] data0, data1;

    assign rr_if.req0  = req0 && (sel == 0);
    assign rr_if.req1  = req1 && (sel == 0);
    assign fp_if.req0  = req0 && (sel != 0);
    assign fp_if.req1  = req1 && (sel != 0);
    assign rr_if.op0   = op0;
    assign rr_if.op1   = op1;
    assign rr_if.data0 = data0;
    assign rr_if.data1 = data1;
    assign fp_if.op0   = op0;
    assign fp_if.op1   = op1;
    assign fp_if.data0 = data0;
    assign fp_if.data1 = data1;

    logic       o_gnt0, o_gnt1, o_done, o_done_id, o_wrap, o_busy;
    logic [7:0] o_result, o_cnt_din, o_cnt_dout;
    logic [1:0] o_cnt_c;

    assign o_gnt0     = (sel != 0) ? fp_if.gnt0    : rr_if.gnt0;
    assign o_gnt1     = (sel != 0) ? fp_if.gnt1    : rr_if.gnt1;
    assign o_done     = (sel != 0) ? fp_if.done    : rr_if.done;
    assign o_done_id  = (sel != 0) ? fp_if.done_id : rr_if.done_id;
    assign o_result   = (sel != 0) ? fp_if.result  : rr_if.result;
    assign o_wrap     = (sel != 0) ? fp_if.wrap    : rr_if.wrap;
    assign o_busy     = (sel != 0) ? fp_if.busy    : rr_if.busy;
    assign o_cnt_c    = (sel != 0) ? cc_fp         : cc_rr;
    assign o_cnt_din  = (sel != 0) ? din_fp        : din_rr;
    assign o_cnt_dout = (sel != 0) ? dout_fp       : dout_rr;

    // Reference model state: counter value and last winner per instance.
    int cnt [2];
    int last [2];
    int checks = 0;
    int errors = 0;

    function automatic int model_apply(input int op, input int d, input int v);
        case (op)
            0: return d % 256;
            1: return (v + 1) % 256;
            2: return (v + 255) % 256;
            default: return 0;
        endcase
    endfunction

    function automatic int model_pick(input int pend, input bit rr_mode, input int lastw);
        if (pend == 3) return rr_mode ? (1 - lastw) : 0;
        return (pend == 1) ? 0 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        int keep;
        keep = sel;
        req0 = 1'b0;
        req1 = 1'b0;
        rst  = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            chk("rst_gnt0", o_gnt0, 0);
            chk("rst_gnt1", o_gnt1, 0);
            chk("rst_done", o_done, 0);
            chk("rst_done_id", o_done_id, 0);
            chk("rst_result", o_result, 0);
            chk("rst_wrap", o_wrap, 0);
            chk("rst_busy", o_busy, 0);
            chk("rst_cnt_c", o_cnt_c, 0);
            chk("rst_cnt_din", o_cnt_din, 0);
        end
        sel = keep;
        rst = 1'b0;
        cnt[0] = 0; cnt[1] = 0;
        last[0] = 1; last[1] = 1;
        tick();
    endtask

    // One burst: requesters in mask raise commands and hold until granted;
    // a winner may immediately re-request with a new command.
    task automatic round(input int mask, input int o0, input int d0,
                         input int o1, input int d1, input int max_rerun);
        int pend, w, pre, nv, rerun;
        int op [2];
        int dat [2];
        bit wr;
        op[0] = o0; dat[0] = d0; op[1] = o1; dat[1] = d1;
        pend  = mask;
        rerun = 0;
        req0  = ((mask & 1) != 0);
        req1  = ((mask & 2) != 0);
        op0   = 2'(o0); data0 = 8'(d0);
        op1   = 2'(o1); data1 = 8'(d1);
        while (pend != 0) begin
            w = model_pick(pend, sel == 0, last[sel]);
            last[sel] = w;
            tick();
            chk("iss_gnt0", o_gnt0, (w == 0));
            chk("iss_gnt1", o_gnt1, (w == 1));
            chk("iss_busy", o_busy, 1);
            chk("iss_done", o_done, 0);
            chk("iss_cnt_c", o_cnt_c, op[w]);
            chk("iss_cnt_din", o_cnt_din, (op[w] == 0) ? dat[w] : 0);
            pre = cnt[sel];
            nv  = model_apply(op[w], dat[w], pre);
            wr  = ((op[w] == 1) && (pre == 255)) || ((op[w] == 2) && (pre == 0));
            if (rerun < max_rerun && $urandom_range(0, 2) == 0) begin
                rerun++;
                op[w]  = int'($urandom_range(0, 3));
                dat[w] = int'($urandom_range(0, 255));
                if (w == 0) begin op0 = 2'(op[0]); data0 = 8'(dat[0]); end
                else        begin op1 = 2'(op[1]); data1 = 8'(dat[1]); end
            end else begin
                pend = pend & ~(1 << w);
                if (w == 0) req0 = 1'b0;
                else        req1 = 1'b0;
            end
            tick();
            chk("cap_done", o_done, 1);
            chk("cap_done_id", o_done_id, w);
            chk("cap_result", o_result, nv);
            chk("cap_wrap", o_wrap, wr);
            chk("cap_gnt0", o_gnt0, 0);
            chk("cap_gnt1", o_gnt1, 0);
            chk("cap_busy", o_busy, 1);
            chk("cap_cnt_dout", o_cnt_dout, nv);
            chk("cap_cnt_c", o_cnt_c, 0);
            chk("cap_cnt_din", o_cnt_din, nv);
            cnt[sel] = nv;
        end
        tick();
        chk("idle_busy", o_busy, 0);
        chk("idle_done", o_done, 0);
        chk("idle_result", o_result, cnt[sel]);
        chk("idle_cnt_din", o_cnt_din, cnt[sel]);
    endtask

    initial begin
        sel = 0;
        rst = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        op0 = 2'd0; op1 = 2'd0;
        data0 = 8'd0; data1 = 8'd0;
        #2;
        do_reset();

        // load then increment from requester 0
        round(1, 0, 25, 0, 0, 0);
        chk("load25_result", o_result, 25);
        chk("load25_id", o_done_id, 0);
        round(1, 1, 0, 0, 0, 0);
        chk("inc26_result", o_result, 26);

        // simultaneous requests after reset: requester 0 first, then 1
        do_reset();
        round(2, 0, 0, 0, 25, 0);
        round(3, 1, 0, 2, 0, 0);
        chk("rr_tie_last_result", o_result, 25);
        chk("rr_tie_last_id", o_done_id, 1);

        // wrap around in both directions
        do_reset();
        round(2, 0, 0, 2, 0, 0);
        chk("dec_wrap_result", o_result, 255);
        chk("dec_wrap_flag", o_wrap, 1);
        round(2, 0, 0, 1, 0, 0);
        chk("inc_wrap_result", o_result, 0);
        chk("inc_wrap_flag", o_wrap, 1);
        round(2, 0, 0, 1, 0, 0);
        chk("inc_nowrap_result", o_result, 1);
        chk("inc_nowrap_flag", o_wrap, 0);

        // idle hold keeps the counter value
        round(1, 0, 77, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_cnt_c", o_cnt_c, 0);
            chk("hold_cnt_din", o_cnt_din, 77);
            chk("hold_cnt_dout", o_cnt_dout, 77);
            chk("hold_busy", o_busy, 0);
        end

        // reset in the middle of ISSUE aborts the operation
        req0 = 1'b1; op0 = 2'd1;
        tick();
        chk("abort_gnt_before", o_gnt0, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_gnt0", o_gnt0, 0);
        chk("abort_busy", o_busy, 0);
        chk("abort_done", o_done, 0);
        chk("abort_result", o_result, 0);
        chk("abort_cnt_dout", o_cnt_dout, 0);
        req0 = 1'b0;
        #2;
        rst = 1'b0;
        cnt[0] = 0; cnt[1] = 0;
        last[0] = 1; last[1] = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_done", o_done, 0);
            chk("abort_idle", o_busy, 0);
        end

        // fixed priority: both held high, requester 1 starves
        sel = 1;
        req0 = 1'b1; op0 = 2'd1; data0 = 8'd0;
        req1 = 1'b1; op1 = 2'd3; data1 = 8'd0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("fp_gnt0", o_gnt0, (i % 2) == 0);
            chk("fp_gnt1", o_gnt1, 0);
            if ((i % 2) == 1) begin
                chk("fp_result", o_result, (cnt[1] + (i + 1) / 2) % 256);
                chk("fp_done_id", o_done_id, 0);
            end
        end
        cnt[1] = (cnt[1] + 5) % 256;
        req0 = 1'b0; req1 = 1'b0;
        tick();
        chk("fp_idle_busy", o_busy, 0);

        // randomized bursts on both instances
        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 1));
            round(int'($urandom_range(1, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
